hs_rx_bridge: RTL and testbench
===============================

HS_RX_BRIDGE -- requirements
Module: hs_rx_bridge

Interface
REQ-001 Parameter DATA_W, default 4: width of the handshake data word and the output word.
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..4: number of flops on the i_data_req synchroniser.
REQ-003 Parameter DEPTH, default 4, power of 2, >=2: number of entries in the receive buffer.
REQ-004 Parameter PROTOCOL, default 0: 0 = four-phase req/ack; 1 = two-phase (toggle) req/ack.
REQ-005 The module SHALL have one clock and one reset, listed first: i_clk_b input 1, the only clock; i_rst_n input 1, reset, synchronous, active-low.
REQ-006 i_data_req  input  1  handshake request from the sender domain; asynchronous to i_clk_b.
REQ-007 i_data  input  DATA_W  sender data; stable from the req transition until the sender sees ack.
REQ-008 o_data_ack  output  1  handshake acknowledge; registered.
REQ-009 o_dout  output  DATA_W  head-of-buffer word, first-word fall-through.
REQ-010 o_dout_valid  output  1  buffer not empty.
REQ-011 i_dout_ready  input  1  consumer accepts o_dout when o_dout_valid=1.
REQ-012 o_fifo_cnt  output  $clog2(DEPTH+1)  current buffer occupancy.
REQ-013 o_busy  output  1  FSM not in IDLE.

Function
REQ-014 i_data_req SHALL pass through SYNC_STAGES flops (req_s = last stage); no other logic SHALL consume raw i_data_req.
REQ-015 pending is defined as: PROTOCOL=0: req_s & ~o_data_ack; PROTOCOL=1: req_s ^ o_data_ack.
REQ-016 The FSM states SHALL be IDLE, WAIT_SPACE and ACK_HOLD.
REQ-017 IDLE, pending=1, buffer not full: write i_data into the buffer on that edge; toggle o_data_ack (PROTOCOL=1) or set it to 1 (PROTOCOL=0) on the same edge; next state is ACK_HOLD (PROTOCOL=0) or IDLE (PROTOCOL=1).
REQ-018 IDLE, pending=1, buffer full: no write, o_data_ack unchanged, go to WAIT_SPACE.
REQ-019 WAIT_SPACE: on the first cycle where the buffer is not full, perform the REQ-017 write/ack action with the same next-state rule.
REQ-020 ACK_HOLD (PROTOCOL=0 only): hold o_data_ack=1 until req_s=0; on that edge, clear o_data_ack and go to IDLE.
REQ-021 "Full" SHALL be evaluated as o_fifo_cnt==DEPTH before any same-cycle pop; a pop in the same cycle does not enable a push.
REQ-022 Latency: a req transition at the pin becomes visible as req_s after SYNC_STAGES edges; the write and ack update occur on the next edge if the buffer has space; o_dout_valid is 1 in the cycle after the write edge.
REQ-023 Pop occurs when o_dout_valid & i_dout_ready; the read pointer advances and o_dout shows the next entry in the following cycle.
REQ-024 A simultaneous push and pop SHALL leave o_fifo_cnt unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 i_dout_ready while empty SHALL have no effect; o_fifo_cnt never exceeds DEPTH and never underflows.
REQ-026 Exactly one buffer write SHALL occur per handshake; no word SHALL be dropped or duplicated.

Reset
REQ-027 When i_rst_n=0 at a rising edge of i_clk_b: synchroniser flops=0, o_data_ack=0, FSM=IDLE, pointers=0, o_fifo_cnt=0, o_dout_valid=0, o_busy=0, o_dout=0.
REQ-028 Reset mid-handshake SHALL discard buffer contents and drop o_data_ack; the sender restarts its transfer.

Verification
REQ-029 PROTOCOL=0, DATA_W=4: i_data=4'hA with req 0->1 -> write at edge 3, o_data_ack=1 after edge 3; req 1->0 -> ack 0 after 3 edges; o_dout=4'hA with o_dout_valid=1.
REQ-030 PROTOCOL=0, DEPTH=4, i_dout_ready=0: send 1,2,3,4,5 -> o_fifo_cnt=4, FSM in WAIT_SPACE, ack stays 0 for word 5; one pop -> word 5 written, ack=1; output order 1..5.
REQ-031 PROTOCOL=1: send 8'h11, 8'h22, 8'h33 as req toggles 0->1->0->1 -> ack toggles 3 times, outputs 11, 22, 33, no extra writes.
REQ-032 Buffer at o_fifo_cnt=2 with simultaneous push and pop -> o_fifo_cnt stays 2; ordering preserved across pointer wrap.
REQ-033 Assert i_rst_n=0 while in ACK_HOLD with o_fifo_cnt=3 -> next cycle o_data_ack=0, o_fifo_cnt=0, o_dout_valid=0, o_busy=0.
REQ-034 Random consumer-ready stall, 1000 transfers -> scoreboard match, no loss or duplication.

Source files
------------

// File: rtl/hs_rx_bridge.sv
// Receives words over an asynchronous req/ack handshake (four-phase or toggle)
// and buffers them in a small first-word fall-through FIFO for the local consumer.
module hs_rx_bridge #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int PROTOCOL    = 0
) (
    input  logic                       i_clk_b,
    input  logic                       i_rst_n,
    input  logic                       i_data_req,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_data_ack,
    output logic [DATA_W-1:0]          o_dout,
    output logic                       o_dout_valid,
    input  logic                       i_dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_fifo_cnt,
    output logic                       o_busy
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam bit TOGGLE = (PROTOCOL != 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        ACK_HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] reqSync_q;
    logic                   ack_q;
    logic                   busy_q;
    state_t                 state_q;
    state_t                 doneState;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]       wrPtr_q;
    logic [PTR_W-1:0]       rdPtr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    logic reqS;
    logic pending;
    logic full;
    logic push;
    logic pop;
    logic ackNext;

    always_ff @(posedge i_clk_b) begin
        if (!i_rst_n) begin
            reqSync_q <= '0;
        end else begin
            reqSync_q <= {reqSync_q[SYNC_STAGES-2:0], i_data_req};
        end
    end

    assign reqS      = reqSync_q[SYNC_STAGES-1];
    assign pending   = TOGGLE ? (reqS ^ ack_q) : (reqS & ~ack_q);
    // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign push      = pending && !full && ((state_q == IDLE) || (state_q == WAIT_SPACE));
    assign pop       = (cnt_q != '0) && i_dout_ready;
    assign ackNext   = TOGGLE ? ~ack_q : 1'b1;
    assign doneState = TOGGLE ? IDLE : ACK_HOLD;

    always_ff @(posedge i_clk_b) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        if (!full) begin
                            ack_q   <= ackNext;
                            state_q <= doneState;
                            busy_q  <= !TOGGLE;
                        end else begin
                            state_q <= WAIT_SPACE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (!pending) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!full) begin
                        ack_q   <= ackNext;
                        state_q <= doneState;
                        busy_q  <= !TOGGLE;
                    end
                end
                ACK_HOLD: begin
                    if (!reqS) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_b) begin
        if (!i_rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents on o_dout.
    always_ff @(posedge i_clk_b) begin
        if (i_rst_n && push) begin
            mem_q[wrPtr_q] <= i_data;
        end
    end

    assign o_data_ack   = ack_q;
    assign o_busy       = busy_q;
    assign o_fifo_cnt   = cnt_q;
    assign o_dout_valid = (cnt_q != '0);
    assign o_dout       = o_dout_valid ? mem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_hs_rx_bridge.sv
// Bench for hs_rx_bridge: a four-phase instance (directed + random traffic with a
// queue scoreboard) and a toggle-protocol instance with 8-bit data.
module tb_hs_rx_bridge;

    logic       clk = 1'b0;
    logic       rstN;

    logic       req0, ack0, valid0, ready0, busy0;
    logic [3:0] data0, dout0;
    logic [2:0] cnt0;

    logic       req1, ack1, valid1, ready1, busy1;
    logic [7:0] data1, dout1;
    logic [2:0] cnt1;

    int testsRun  = 0;
    int failCount = 0;
    int toggles1  = 0;
    logic ack1Prev = 1'b0;

    logic [3:0] expQ[$];
    int  popped     = 0;
    bit  senderDone = 1'b0;

    always #5 clk = ~clk;

    hs_rx_bridge #(.DATA_W(4), .SYNC_STAGES(2), .DEPTH(4), .PROTOCOL(0)) dut0 (
        .i_clk_b(clk), .i_rst_n(rstN), .i_data_req(req0), .i_data(data0),
        .o_data_ack(ack0), .o_dout(dout0), .o_dout_valid(valid0),
        .i_dout_ready(ready0), .o_fifo_cnt(cnt0), .o_busy(busy0)
    );

    hs_rx_bridge #(.DATA_W(8), .SYNC_STAGES(2), .DEPTH(4), .PROTOCOL(1)) dut1 (
        .i_clk_b(clk), .i_rst_n(rstN), .i_data_req(req1), .i_data(data1),
        .o_data_ack(ack1), .o_dout(dout1), .o_dout_valid(valid1),
        .i_dout_ready(ready1), .o_fifo_cnt(cnt1), .o_busy(busy1)
    );

    // Each change of the toggle-protocol acknowledge is one completed handshake.
    always @(negedge clk) begin
        if (ack1 !== ack1Prev) toggles1++;
        ack1Prev = ack1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitAck(input int which, input logic val, input string tag);
        int n = 0;
        while (((which == 0) ? ack0 : ack1) !== val && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'((which == 0) ? ack0 : ack1), 32'(val));
    endtask

    // Full four-phase transfer as the sender would do it.
    task automatic applyStimulus(input logic [3:0] d);
        data0 = d;
        req0  = 1'b1;
        waitAck(0, 1'b1, "ackRise");
        req0  = 1'b0;
        waitAck(0, 1'b0, "ackFall");
    endtask

    task automatic popCheck0(input logic [3:0] exp);
        checkOutput("popValid", 32'(valid0), 1);
        checkOutput("popData", 32'(dout0), 32'(exp));
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
    endtask

    task automatic popCheck1(input logic [7:0] exp);
        checkOutput("popValid1", 32'(valid1), 1);
        checkOutput("popData1", 32'(dout1), 32'(exp));
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
    endtask

    task automatic checkIdleReset();
        checkOutput("rstAck", 32'(ack0), 0);
        checkOutput("rstCnt", 32'(cnt0), 0);
        checkOutput("rstValid", 32'(valid0), 0);
        checkOutput("rstBusy", 32'(busy0), 0);
        checkOutput("rstDout", 32'(dout0), 0);
    endtask

    initial begin
        rstN = 1'b0;
        req0 = 1'b0; data0 = '0; ready0 = 1'b0;
        req1 = 1'b0; data1 = '0; ready1 = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleReset();
        checkOutput("rstAck1", 32'(ack1), 0);
        rstN = 1'b1;
        @(negedge clk);

        // Single four-phase word: write and ack on the third edge after req rises.
        data0 = 4'hA;
        req0  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("lat2Ack", 32'(ack0), 0);
        checkOutput("lat2Valid", 32'(valid0), 0);
        @(negedge clk);
        checkOutput("lat3Ack", 32'(ack0), 1);
        checkOutput("lat3Valid", 32'(valid0), 1);
        checkOutput("lat3Dout", 32'(dout0), 32'hA);
        checkOutput("lat3Cnt", 32'(cnt0), 1);
        checkOutput("lat3Busy", 32'(busy0), 1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("holdAck", 32'(ack0), 1);
        @(negedge clk);
        checkOutput("dropAck", 32'(ack0), 0);
        checkOutput("dropBusy", 32'(busy0), 0);
        popCheck0(4'hA);
        checkOutput("emptyCnt", 32'(cnt0), 0);

        // Ready while empty must not underflow.
        ready0 = 1'b1;
        repeat (2) @(negedge clk);
        ready0 = 1'b0;
        checkOutput("underflowCnt", 32'(cnt0), 0);
        checkOutput("underflowValid", 32'(valid0), 0);

        // Fill the buffer, fifth word must stall until a pop frees an entry.
        for (int i = 1; i <= 4; i++) applyStimulus(4'(i));
        checkOutput("fullCnt", 32'(cnt0), 4);
        data0 = 4'h5;
        req0  = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("stallAck", 32'(ack0), 0);
        checkOutput("stallCnt", 32'(cnt0), 4);
        checkOutput("stallBusy", 32'(busy0), 1);
        checkOutput("stallHead", 32'(dout0), 1);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        checkOutput("popNoPushAck", 32'(ack0), 0);
        checkOutput("popNoPushCnt", 32'(cnt0), 3);
        @(negedge clk);
        checkOutput("lateAck", 32'(ack0), 1);
        checkOutput("lateCnt", 32'(cnt0), 4);
        req0 = 1'b0;
        waitAck(0, 1'b0, "lateAckFall");
        for (int i = 2; i <= 5; i++) popCheck0(4'(i));
        checkOutput("drainValid", 32'(valid0), 0);

        // Simultaneous push and pop at count 2, across the pointer wrap.
        applyStimulus(4'h6);
        applyStimulus(4'h7);
        data0 = 4'h8;
        req0  = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("pushPopHead", 32'(dout0), 6);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        checkOutput("pushPopCnt", 32'(cnt0), 2);
        checkOutput("pushPopAck", 32'(ack0), 1);
        req0 = 1'b0;
        waitAck(0, 1'b0, "pushPopAckFall");
        popCheck0(4'h7);
        popCheck0(4'h8);

        // Reset while holding the ack with three words buffered.
        applyStimulus(4'h9);
        applyStimulus(4'hB);
        data0 = 4'hC;
        req0  = 1'b1;
        waitAck(0, 1'b1, "holdBeforeRst");
        checkOutput("preRstCnt", 32'(cnt0), 3);
        checkOutput("preRstBusy", 32'(busy0), 1);
        rstN = 1'b0;
        @(negedge clk);
        checkIdleReset();
        rstN = 1'b1;
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("postRstAck", 32'(ack0), 0);
        checkOutput("postRstCnt", 32'(cnt0), 0);

        // Toggle protocol: three words over req 0->1->0->1.
        toggles1 = 0;
        data1 = 8'h11; req1 = 1'b1;
        waitAck(1, 1'b1, "tgAck1");
        data1 = 8'h22; req1 = 1'b0;
        waitAck(1, 1'b0, "tgAck2");
        data1 = 8'h33; req1 = 1'b1;
        waitAck(1, 1'b1, "tgAck3");
        repeat (6) @(negedge clk);
        checkOutput("tgToggles", 32'(toggles1), 3);
        checkOutput("tgCnt", 32'(cnt1), 3);
        checkOutput("tgBusy", 32'(busy1), 0);
        popCheck1(8'h11);
        popCheck1(8'h22);
        popCheck1(8'h33);
        checkOutput("tgEmpty", 32'(valid1), 0);

        // Random traffic: sender with random gaps, consumer with random stalls.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [3:0] d;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    d = 4'($urandom);
                    expQ.push_back(d);
                    applyStimulus(d);
                end
                senderDone = 1'b1;
            end
            begin
                int cyc = 0;
                while (!(senderDone && expQ.size() == 0) && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    ready0 = ($urandom_range(0, 3) != 0);
                    if (valid0 && ready0) begin
                        if (expQ.size() == 0) begin
                            checkOutput("extraWord", 32'(expQ.size()), 1);
                        end else begin
                            checkOutput("rndData", 32'(dout0), 32'(expQ.pop_front()));
                            popped++;
                        end
                    end
                end
                ready0 = 1'b0;
            end
        join
        @(negedge clk);
        checkOutput("rndPopped", 32'(popped), 1000);
        checkOutput("rndLeftover", 32'(expQ.size()), 0);
        checkOutput("rndCnt", 32'(cnt0), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
